// File: rtl/halflife_input_cond.sv
// rtl/halflife_input_cond.sv - button sync/debounce, pulse and auto-repeat generation for the half-life counter core
module halflife_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic       load_btn,
  input  logic [3:0] in_raw,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       load_pulse,
  output logic [3:0] in_q
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RATE_LAST  = RW'(REPEAT_RATE - 1);

  // Button index: 0 = up, 1 = down, 2 = load.
  logic [2:0]     btn_s1_q, btn_s2_q;
  logic [3:0]     in_s1_q, in_s2_q;
  logic [2:0]     lvl_q, lvl_d, rise;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];
  logic [RW-1:0]  rcnt_q [2];
  logic [RW-1:0]  rcnt_d [2];
  logic [1:0]     rphase_q, rphase_d, fire;
  logic           both_q, both_d;
  logic           up_d, down_d, load_d;
  logic [3:0]     in_d;

  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) lvl_d[i] = btn_s2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise   = lvl_d & ~lvl_q;
  assign both_q = lvl_q[0] & lvl_q[1];
  assign both_d = lvl_d[0] & lvl_d[1];

  // Repeat timing restarts whenever a direction is not held alone, on either side of the edge.
  always_comb begin
    rphase_d = rphase_q;
    fire     = '0;
    for (int i = 0; i < 2; i++) begin
      rcnt_d[i] = '0;
      fire[i] = REPEAT_EN && lvl_q[i] && lvl_d[i] && !both_q && !both_d &&
                (rcnt_q[i] == (rphase_q[i] ? RATE_LAST : DELAY_LAST));
      if (fire[i]) begin
        rphase_d[i] = 1'b1;
      end else if (!lvl_d[i] || rise[i] || both_q || both_d || !REPEAT_EN) begin
        rphase_d[i] = 1'b0;
      end else begin
        rcnt_d[i] = rcnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    load_d = rise[2];
    up_d   = (rise[0] | fire[0]) & ~both_d & ~load_d;
    down_d = (rise[1] | fire[1]) & ~both_d & ~load_d;
    in_d   = rise[2] ? in_s2_q : in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      in_s1_q    <= '0;
      in_s2_q    <= '0;
      lvl_q      <= '0;
      rphase_q   <= '0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      load_pulse <= 1'b0;
      in_q       <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
    end else begin
      btn_s1_q   <= {load_btn, down_btn, up_btn};
      btn_s2_q   <= btn_s1_q;
      in_s1_q    <= in_raw;
      in_s2_q    <= in_s1_q;
      lvl_q      <= lvl_d;
      rphase_q   <= rphase_d;
      up_pulse   <= up_d;
      down_pulse <= down_d;
      load_pulse <= load_d;
      in_q       <= in_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < 2; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

endmodule

// File: tb/tb_halflife_input_cond.sv
// tb/tb_halflife_input_cond.sv - directed self-checking bench for halflife_input_cond
module tb_halflife_input_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_btn, down_btn, load_btn;
  logic [3:0] in_raw;
  logic       up_pulse, down_pulse, load_pulse;
  logic [3:0] in_q;

  int ntests = 0;
  int nfail  = 0;

  halflife_input_cond #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_RATE(3),
    .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .up_btn(up_btn),
    .down_btn(down_btn),
    .load_btn(load_btn),
    .in_raw(in_raw),
    .up_pulse(up_pulse),
    .down_pulse(down_pulse),
    .load_pulse(load_pulse),
    .in_q(in_q)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic eu, input logic ed, input logic el);
    step();
    chk({tag, "_up"},   {3'b0, up_pulse},   {3'b0, eu});
    chk({tag, "_down"}, {3'b0, down_pulse}, {3'b0, ed});
    chk({tag, "_load"}, {3'b0, load_pulse}, {3'b0, el});
  endtask

  initial begin
    logic [4:0] pat;

    // Reset with every button held, then a fresh press on all three.
    rst = 1'b1; up_btn = 1'b1; down_btn = 1'b1; load_btn = 1'b1; in_raw = 4'h5;
    for (int k = 0; k < 3; k++) begin
      cyc("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_in_q", in_q, 4'h0);
    end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin up_btn = 1'b0; down_btn = 1'b0; load_btn = 1'b0; end
      cyc("t1_post_rst", 1'b0, 1'b0, k == 5);
      if (k >= 5) chk("t1_in_q", in_q, 4'h5);
    end

    // Clean up press, held: initial pulse then repeats until debounced release.
    up_btn = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k == 25) up_btn = 1'b0;
      cyc("t2_up_hold", k inside {5, 13, 16, 19, 22, 25, 28}, 1'b0, 1'b0);
    end

    // Bounce 1,0,1,1,0 then low.
    pat = 5'b01101;
    for (int k = 0; k <= 12; k++) begin
      up_btn = (k < 5) ? pat[k] : 1'b0;
      cyc("t3_bounce", 1'b0, 1'b0, 1'b0);
    end
    chk("t3_db_cnt_clear", {1'b0, dut.db_cnt_q[0]}, 4'h0);

    // Glitch of DEBOUNCE_CYCLES-1 cycles is ignored.
    for (int k = 0; k <= 12; k++) begin
      up_btn = (k < 3);
      cyc("t3_glitch3", 1'b0, 1'b0, 1'b0);
    end

    // Exactly DEBOUNCE_CYCLES cycles is accepted as one press.
    for (int k = 0; k <= 14; k++) begin
      up_btn = (k < 4);
      cyc("t3_press4", k == 5, 1'b0, 1'b0);
    end

    // Load captures the synchronised preset and holds it; load never repeats.
    in_raw = 4'hA; load_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) in_raw = 4'h3;
      cyc("t4_load", 1'b0, 1'b0, k == 5);
      chk("t4_in_q", in_q, (k < 5) ? 4'h5 : 4'hA);
    end
    load_btn = 1'b0;
    for (int k = 0; k < 10; k++) cyc("t4_release", 1'b0, 1'b0, 1'b0);
    chk("t4_in_q_hold", in_q, 4'hA);
    load_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc("t4_reload", 1'b0, 1'b0, k == 5);
      chk("t4_in_q2", in_q, (k < 5) ? 4'hA : 4'h3);
    end
    load_btn = 1'b0;
    for (int k = 0; k < 10; k++) cyc("t4_idle", 1'b0, 1'b0, 1'b0);

    // Up held, down joins: both suppressed; down resumes repeat after up releases.
    up_btn = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      if (k == 2)  down_btn = 1'b1;
      if (k == 20) up_btn = 1'b0;
      if (k == 37) down_btn = 1'b0;
      cyc("t5_up_down", k == 5, k inside {33, 36, 39}, 1'b0);
    end

    // Load and up rise together: load wins, up repeat timing unaffected.
    load_btn = 1'b1; up_btn = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      if (k == 15) begin load_btn = 1'b0; up_btn = 1'b0; end
      cyc("t6_load_up", k inside {13, 16, 19}, 1'b0, k == 5);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
